// File: rtl/prog_loader.sv
// Program image loader: receives DEPTH bytes plus an optional checksum byte over a
// valid/ready stream, stores them, and exposes them to the CPU fetch port.
module prog_loader #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned DW       = 8,
  parameter bit          CHECKSUM = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          image_ok,
  output logic          cpu_hold
);

  typedef enum logic [1:0] {IDLE, LOAD, CSUM} state_t;

  state_t        state, state_d;
  logic [AW-1:0] addr, addr_d;
  logic [DW-1:0] sum, sum_d;
  logic [DW-1:0] csum_total;
  logic          err_d, image_ok_d, done_d, busy_d, we;
  logic [DW-1:0] mem [DEPTH];

  assign csum_total = sum + s_data;

  // Next-state, datapath updates and stream ready
  always_comb begin
    state_d    = state;
    addr_d     = addr;
    sum_d      = sum;
    err_d      = err;
    image_ok_d = image_ok;
    done_d     = 1'b0;
    we         = 1'b0;
    s_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          addr_d     = '0;
          sum_d      = '0;
          err_d      = 1'b0;
          image_ok_d = 1'b0;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          we     = 1'b1;
          sum_d  = csum_total;
          addr_d = addr + AW'(1);
          if (addr == AW'(DEPTH - 1)) begin
            if (CHECKSUM) begin
              state_d = CSUM;
            end else begin
              state_d    = IDLE;
              image_ok_d = 1'b1;
              done_d     = 1'b1;
            end
          end
        end
      end
      CSUM: begin
        // Checksum byte is consumed but never written to memory
        s_ready = 1'b1;
        if (s_valid) begin
          if (csum_total == '0) image_ok_d = 1'b1;
          else                  err_d      = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      sum      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      image_ok <= 1'b0;
    end else begin
      state    <= state_d;
      addr     <= addr_d;
      sum      <= sum_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      image_ok <= image_ok_d;
    end
  end

  // Program memory; reset clears the whole image
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[addr] <= s_data;
    end
  end

  assign rd_data  = mem[rd_addr];
  assign cpu_hold = busy | ~image_ok;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: randomized and directed loads against a
// byte-array reference model; a monitor checks every done pulse against a queue.
module tb_prog_loader;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy, done, err, image_ok, cpu_hold;

  always #5 clk = ~clk;

  prog_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CHECKSUM(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .done(done), .err(err), .image_ok(image_ok), .cpu_hold(cpu_hold)
  );

  typedef struct packed {
    logic err;
    logic ok;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] model_mem [16];
  logic [7:0] img [16];
  int         checks = 0;
  int         errors = 0;
  int         done_seen = 0;
  int         done_expected = 0;
  logic       prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_seen++;
      check("done_single_cycle", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_err", 32'(err), 32'(e.err));
        check("done_image_ok", 32'(image_ok), 32'(e.ok));
        check("done_cpu_hold", 32'(cpu_hold), 32'(!e.ok));
        check("done_busy", 32'(busy), 32'd0);
      end
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
  endtask

  task automatic idle_gap(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      s_data = 8'($urandom);
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_start);
    s_valid = 1'b1;
    s_data  = b;
    start   = with_start;
    check("s_ready_busy", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic sweep();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      tick();
      check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(model_mem[a]));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared_on_start", 32'(err), 32'd0);
    check("image_ok_cleared_on_start", 32'(image_ok), 32'd0);
  endtask

  function automatic int gap_len(input int mode);
    if (mode == 1) return 2;
    if (mode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  // One full load of img plus csum; bs_a/bs_b are byte slots (16 = checksum) where start is re-pulsed
  task automatic load(input logic [7:0] csum, input int mode, input int bs_a, input int bs_b,
                      input bit do_sweep);
    logic [7:0] total;
    bit         ok;
    exp_t       e;
    pulse_start();
    total = 8'h00;
    for (int i = 0; i < 16; i++) begin
      send_byte(img[i], (i == bs_a) || (i == bs_b));
      model_mem[i] = img[i];
      total = total + img[i];
      idle_gap(gap_len(mode));
    end
    ok = ((total + csum) == 8'h00);
    e.err = !ok;
    e.ok  = ok;
    exp_q.push_back(e);
    done_expected++;
    send_byte(csum, (bs_a == 16) || (bs_b == 16));
    check("s_ready_after_load", 32'(s_ready), 32'd0);
    check("cpu_hold_after_load", 32'(cpu_hold), 32'(!ok));
    if (do_sweep) sweep();
  endtask

  initial begin
    logic [7:0] total;
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] total;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'hxx;

    // Reset state
    do_reset(2);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_image_ok", 32'(image_ok), 32'd0);
    check("reset_cpu_hold", 32'(cpu_hold), 32'd1);
    check("reset_s_ready", 32'(s_ready), 32'd0);
    sweep();

    // Good load, bad checksum, then a good load started in the done cycle
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    load(8'h88, 0, -1, -1, 1'b1);
    load(8'h00, 0, -1, -1, 1'b1);
    check("bad_err_sticky", 32'(err), 32'd1);
    load(8'h00, 0, -1, -1, 1'b0);
    load(8'h88, 0, -1, -1, 1'b1);
    check("good_after_bad_err", 32'(err), 32'd0);
    check("good_after_bad_ok", 32'(image_ok), 32'd1);

    // Gapped stream of 0xB3
    for (int i = 0; i < 16; i++) img[i] = 8'hB3;
    load(8'hD0, 1, -1, -1, 1'b1);

    // Start while busy, including during the checksum byte
    for (int i = 0; i < 16; i++) img[i] = 8'(8'h40 + i);
    load(8'h38, 2, 4, 16, 1'b1);

    // Reset mid-load
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(8'(8'hA0 + i), 1'b0);
    do_reset(1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_image_ok", 32'(image_ok), 32'd0);
    check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    idle_gap(3);
    check("midrst_s_ready_idle", 32'(s_ready), 32'd0);
    sweep();

    // Randomized loads
    for (int n = 0; n < 8; n++) begin
      total = 8'h00;
      for (int i = 0; i < 16; i++) begin
        img[i] = 8'($urandom);
        total = total + img[i];
      end
      if ($urandom_range(0, 2) != 0) total = 8'(8'h00 - total);
      else                           total = 8'($urandom);
      load(total, int'($urandom_range(0, 2)), int'($urandom_range(0, 20)),
           int'($urandom_range(0, 20)), 1'b1);
    end

    idle_gap(4);
    check("done_count", 32'(done_seen), 32'(done_expected));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Writes the 16 x 8-bit program image that the 4-bit CPU core fetches, in place of a fixed ROM. Bytes arrive on a valid/ready byte stream, followed by one two's-complement checksum byte. The block exposes a combinational read port indexed by the CPU program counter. It drives cpu_hold so the core stays parked until a verified image is present.

Parameters:
DEPTH, 16, number of program words; must equal 2**AW
AW, 4, address width; matches the CPU program counter
DW, 8, word width; opcode[7:4] plus immediate[3:0]
CHECKSUM, 1, 1 = expect a checksum byte after the image; 0 = no checksum byte, image accepted unconditionally

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle request to begin a load; sampled only in IDLE
s_valid  input  1  stream byte valid
s_ready  output  1  stream byte ready; transfer occurs when s_valid & s_ready at a rising edge
s_data  input  DW  stream byte
rd_addr  input  AW  CPU fetch address
rd_data  output  DW  program word at rd_addr; combinational
busy  output  1  high in LOAD and CSUM states
done  output  1  one-cycle pulse when a load sequence ends, whether it passes or fails
err  output  1  checksum mismatch; sticky until the next accepted start or rst
image_ok  output  1  memory holds a verified image
cpu_hold  output  1  busy | ~image_ok; drives the CPU reset/stall

Behaviour:
- Interface: one clock, clk; rst is synchronous, active-high. All outputs except rd_data, s_ready and cpu_hold are registered.
- Reset, effective at a clk edge with rst=1:
  - state=IDLE; all DEPTH words cleared to 0
  - addr=0, sum=0
  - busy=0, done=0, err=0, image_ok=0, so cpu_hold=1
  - reset overrides every other input in that cycle
- States: IDLE, LOAD, CSUM.
- IDLE:
  - s_ready=0
  - start=1 -> LOAD; addr<=0, sum<=0, err<=0, image_ok<=0
  - start=0 -> stay
- LOAD:
  - s_ready=1
  - each handshake: mem[addr]<=s_data; sum<=sum+s_data (mod 2**DW); addr<=addr+1
  - handshake with addr==DEPTH-1 and CHECKSUM=1 -> CSUM
  - handshake with addr==DEPTH-1 and CHECKSUM=0 -> IDLE, image_ok<=1, done<=1
  - cycles with s_valid=0 hold all state; there is no timeout
- CSUM:
  - s_ready=1; the byte is not written to memory
  - on handshake: if sum+s_data==0 (mod 2**DW) then image_ok<=1, else err<=1; done<=1; -> IDLE
- done: high exactly one cycle, the first IDLE cycle after the final handshake; image_ok/err are valid in that same cycle.
- start while busy is ignored; it neither restarts nor aborts the load.
- start in the same cycle as done is accepted (state is already IDLE).
- addr wraps naturally at DEPTH; its value after the final handshake is don't-care.
- rd_data=mem[rd_addr] at all times, including during LOAD, when it may return partially written contents.
- Write and read to the same address in the same cycle: rd_data shows the old value until the edge.
- A failed load leaves the memory with the received bytes but image_ok=0; cpu_hold stays 1 until a successful load.
- rst mid-load: memory cleared, state IDLE, no done pulse.

Test Plan:
- Reset: assert rst 2 cycles -> busy=0, done=0, err=0, image_ok=0, cpu_hold=1, s_ready=0, rd_data=0x00 for every rd_addr 0..15.
- Good load: start, then bytes 0x00..0x0F back-to-back, then checksum 0x88 (0x78+0x88=0x100) -> done high 1 cycle, image_ok=1, err=0, cpu_hold=0; rd_addr=5 -> 0x05, rd_addr=15 -> 0x0F.
- Bad checksum: same 16 bytes, checksum 0x00 -> done pulse, err=1, image_ok=0, cpu_hold=1; rd_addr=3 -> 0x03. Follow with a good load -> err=0, image_ok=1.
- Gapped stream: s_valid toggled 1,0,0,1,... with image 0xB3 repeated 16 times (sum 0x30), checksum 0xD0 -> all 16 words read 0xB3, image_ok=1, done asserted exactly once.
- Start while busy: pulse start after byte 4 and again during CSUM -> load continues; 16 bytes plus 1 checksum byte consumed; single done pulse.
- Reset mid-load: rst after 7 bytes -> busy=0, image_ok=0, no done pulse, all words 0x00; s_ready=0 until the next start.
